// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the pipelined on-chip RAM slave.
// Holds the FSM state encoding, read-latency constants and the byteenable width helper.
package onchip_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RD_LAT_BASE   = 1;
  localparam int RD_LAT_OUTREG = 2;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Byte-enabled synchronous single-port array with a registered, enable-gated read port.
// No control logic; the read register only loads on a read so it holds between reads.
module onchip_ram_core
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clken,
  input  logic                          we,
  input  logic                          re,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [be_width(DATA_WIDTH)-1:0] be,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int BW    = be_width(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clken && we) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read-before-write: a same-cycle write is visible to the next cycle's read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (clken && re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/onchip_ram_pipelined.sv
// Pipelined Avalon-MM on-chip RAM slave with post-reset clear sweep.
// Define ONCHIP_RAM_OUTREG_EN for an extra readdata/readdatavalid register (latency 2).
module onchip_ram_pipelined
  import onchip_ram_pkg::*;
#(
  parameter int                        DATA_WIDTH = 32,
  parameter int                        ADDR_WIDTH = 13,
  parameter int                        INIT_CLEAR = 1,
  parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic [be_width(DATA_WIDTH)-1:0] byteenable,
  input  logic                            chipselect,
  input  logic                            read,
  input  logic                            write,
  input  logic [DATA_WIDTH-1:0]           writedata,
  input  logic                            clken,
  input  logic                            reset_req,
  output logic [DATA_WIDTH-1:0]           readdata,
  output logic                            readdatavalid,
  output logic                            waitrequest
);

  localparam int BW = be_width(DATA_WIDTH);

  state_t                     state, state_nxt;
  logic [ADDR_WIDTH-1:0]      sweep_addr;
  logic                       in_init;
  logic                       accept, wr_acc, rd_acc;
  logic                       mem_we;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [BW-1:0]              mem_be;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [DATA_WIDTH-1:0]      core_rdata;
  logic                       rd_vld;

  assign in_init = (state == ST_INIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if (INIT_CLEAR != 0) state <= ST_INIT;
      else                 state <= ST_READY;
      sweep_addr <= '0;
    end else if (clken) begin
      state <= state_nxt;
      if (in_init) sweep_addr <= sweep_addr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && sweep_addr == '1) state_nxt = ST_READY;
  end

  assign waitrequest = reset | in_init | ~clken | reset_req;
  assign accept      = chipselect & (read | write) & ~waitrequest;
  assign wr_acc      = accept & write;
  // A simultaneous read and write performs only the write.
  assign rd_acc      = accept & read & ~write;

  assign mem_we    = in_init ? clken       : wr_acc;
  assign mem_addr  = in_init ? sweep_addr  : address;
  assign mem_be    = in_init ? {BW{1'b1}}  : byteenable;
  assign mem_wdata = in_init ? INIT_VALUE  : writedata;

  onchip_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .clken (clken),
    .we    (mem_we),
    .re    (rd_acc),
    .addr  (mem_addr),
    .be    (mem_be),
    .wdata (mem_wdata),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_vld <= 1'b0;
    else if (clken) rd_vld <= rd_acc;
  end

  // Valid bits are held while frozen and only shown once clken returns.
`ifdef ONCHIP_RAM_OUTREG_EN
  logic                  out_vld;
  logic [DATA_WIDTH-1:0] out_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (clken) begin
      out_vld <= rd_vld;
      if (rd_vld) out_dat <= core_rdata;
    end
  end

  assign readdata      = out_dat;
  assign readdatavalid = out_vld & clken;
`else
  assign readdata      = core_rdata;
  assign readdatavalid = rd_vld & clken;
`endif

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Scoreboard bench for onchip_ram_pipelined: directed commands push expected read data and
// arrival cycle; a negedge monitor pops and compares each readdatavalid pulse.
module tb_onchip_ram_pipelined;

`ifdef ONCHIP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int SWEEP = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] address;
  logic [3:0]  byteenable;
  logic        chipselect, read, write;
  logic [31:0] writedata;
  logic        clken, reset_req;
  logic [31:0] readdata;
  logic        readdatavalid, waitrequest;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  onchip_ram_pipelined dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .byteenable    (byteenable),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .clken         (clken),
    .reset_req     (reset_req),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    else n_pass++;
  endtask

  // Monitor: every readdatavalid pulse must match the oldest expectation in data and cycle.
  always @(negedge clk) begin
    if (!reset && readdatavalid) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: readdata 0x%08h at cycle %0d with nothing expected", readdata, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("read_data", readdata, e.d);
        chk("read_cycle", cyc, e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic r, input logic w, input logic [12:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp_d, input int extra);
    exp_t e;
    chipselect = 1'b1; read = r; write = w;
    address = a; writedata = d; byteenable = be;
    if (r && !w) begin
      e.d = exp_d;
      e.c = cyc + LAT + extra;
      q.push_back(e);
    end
    step();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    cmd(1'b1 ^ 1'b1, 1'b1, a, d, be, 32'h0, 0);
  endtask

  task automatic rd(input logic [12:0] a, input logic [31:0] exp_d);
    cmd(1'b1, 1'b0, a, 32'h0, 4'hF, exp_d, 0);
  endtask

  // Counts negedges with waitrequest high after reset release; bounded.
  task automatic count_sweep(input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 3 * SWEEP; i++) begin
      @(negedge clk);
      if (waitrequest) cnt++;
      else break;
    end
    chk(name, cnt, SWEEP);
    step();
  endtask

  initial begin
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; byteenable = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", {31'b0, waitrequest}, 32'h1);
    chk("rst_readdatavalid", {31'b0, readdatavalid}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    step();
    reset = 1'b0;
    count_sweep("sweep_len");

    rd(13'h1FFF, 32'h0);
    chk("ready_waitrequest", {31'b0, waitrequest}, 32'h0);

    // Byte-lane merge.
    wr(13'd5, 32'hFFFF_FFFF, 4'hF);
    wr(13'd5, 32'hDEAD_BEEF, 4'b0101);
    rd(13'd5, 32'hFFAD_FFEF);

    // Back-to-back reads.
    wr(13'd1, 32'h11, 4'hF);
    wr(13'd2, 32'h22, 4'hF);
    wr(13'd3, 32'h33, 4'hF);
    rd(13'd1, 32'h11);
    rd(13'd2, 32'h22);
    rd(13'd3, 32'h33);

    // Read-after-write in the next cycle.
    wr(13'd9, 32'h1234_5678, 4'hF);
    rd(13'd9, 32'h1234_5678);
    step();

    // Read and write together: write wins, no valid.
    cmd(1'b1, 1'b1, 13'd7, 32'hA5, 4'hF, 32'h0, 0);
    step();
    rd(13'd7, 32'hA5);
    step();

    // Freeze with a read in flight.
    cmd(1'b1, 1'b0, 13'd2, 32'h0, 4'hF, 32'h22, 4);
    clken = 1'b0;
    #1 chk("freeze_waitrequest", {31'b0, waitrequest}, 32'h1);
    repeat (4) step();
    clken = 1'b1;
    repeat (3) step();

    // reset_req blocks acceptance.
    reset_req = 1'b1;
    chipselect = 1'b1; read = 1'b1; address = 13'd1;
    #1 chk("reset_req_waitrequest", {31'b0, waitrequest}, 32'h1);
    step();
    chipselect = 1'b0; read = 1'b0; reset_req = 1'b0;
    repeat (3) step();

    // Reset at sweep word 100: full restart, untouched high word cleared too.
    wr(13'h1F00, 32'hCAFE_F00D, 4'hF);
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (100) step();
    reset = 1'b1;
    #1 chk("midsweep_rst_waitrequest", {31'b0, waitrequest}, 32'h1);
    repeat (2) step();
    reset = 1'b0;
    count_sweep("restart_sweep_len");
    rd(13'h1F00, 32'h0);
    rd(13'd5, 32'h0);

    repeat (6) step();
    chk("queue_empty", q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
